// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcode enum and the generic per-stage record.
package alu_pipe_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned MAX_W = 48;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 4'h0,
        OP_OR   = 4'h1,
        OP_XOR  = 4'h2,
        OP_ADD  = 4'h3,
        OP_ADDC = 4'h4,
        OP_SUB  = 4'h5,
        OP_SEQ  = 4'h6,
        OP_SLTU = 4'h7,
        OP_SLTS = 4'h8,
        OP_SLL  = 4'h9,
        OP_SRL  = 4'hA,
        OP_MUL  = 4'hB
    } op_t;

    // Widest-case stage record; the top narrows data to DATA_W via its own lane type.
    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] data;
        logic             carry;
        logic             illegal;
    } stage_t;

endpackage

// File: rtl/alu_pipe_stage.sv
// One delay register of the ALU result pipeline; clears on async reset or flush.
module alu_pipe_stage
    import alu_pipe_pkg::*;
#(
    parameter type stage_type = stage_t
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      flush,
    input  stage_type d,
    output stage_type q
);

    // Upstream already zeroes data of invalid entries, so a plain copy keeps that invariant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Parametrised pipelined integer ALU: compute in stage 1, LATENCY-1 delay stages after.
// Optional multiplier on op B enabled by defining ALU_PIPE_MUL_EN.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              carryin,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out,
    output logic              carryout,
    output logic              out_illegal
);

    localparam int unsigned SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              carry;
        logic              illegal;
    } lane_t;

    op_t             op;
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [SH_W-1:0] shamt;
    lane_t           result;
    lane_t           s1;
    lane_t           chain [LATENCY];

    assign op    = op_t'(in_op);
    assign shamt = in1[SH_W-1:0];
    assign sum   = {1'b0, in0} + {1'b0, in1} + {{DATA_W{1'b0}}, (op == OP_ADDC) & carryin};
    assign diff  = {1'b0, in0} - {1'b0, in1};

`ifdef ALU_PIPE_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, in0} * {{DATA_W{1'b0}}, in1};
`endif

    always_comb begin
        result       = '0;
        result.valid = 1'b1;
        case (op)
            OP_AND:  result.data = in0 & in1;
            OP_OR:   result.data = in0 | in1;
            OP_XOR:  result.data = in0 ^ in1;
            OP_ADD,
            OP_ADDC: begin
                result.data  = sum[DATA_W-1:0];
                result.carry = sum[DATA_W];
            end
            OP_SUB: begin
                result.data  = diff[DATA_W-1:0];
                result.carry = diff[DATA_W];
            end
            OP_SEQ:  result.data = {{(DATA_W-1){1'b0}}, in0 == in1};
            OP_SLTU: result.data = {{(DATA_W-1){1'b0}}, in0 < in1};
            OP_SLTS: result.data = {{(DATA_W-1){1'b0}}, $signed(in0) < $signed(in1)};
            OP_SLL:  result.data = in0 << shamt;
            OP_SRL:  result.data = in0 >> shamt;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: begin
                result.data  = prod[DATA_W-1:0];
                result.carry = |prod[2*DATA_W-1:DATA_W];
            end
`endif
            default: result.illegal = 1'b1;
        endcase
    end

    // Stage 1 zeroes the whole record when nothing valid is captured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
        end else if (flush || !in_valid) begin
            s1 <= '0;
        end else begin
            s1 <= result;
        end
    end

    assign chain[0] = s1;

    for (genvar g = 0; g < LATENCY - 1; g++) begin : g_stage
        alu_pipe_stage #(
            .stage_type(lane_t)
        ) u_stage (
            .clock(clock),
            .reset(reset),
            .flush(flush),
            .d    (chain[g]),
            .q    (chain[g+1])
        );
    end

    assign out_valid   = chain[LATENCY-1].valid;
    assign out         = chain[LATENCY-1].data;
    assign carryout    = chain[LATENCY-1].carry;
    assign out_illegal = chain[LATENCY-1].illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, scoreboarded random ops, flush, latency and reset.
module tb_alu_pipe;

    localparam int LAT = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // 16-bit, latency-2 instance
    logic        reset, in_valid, carryin, flush;
    logic [3:0]  in_op;
    logic [15:0] in0, in1;
    logic        out_valid, carryout, out_illegal;
    logic [15:0] out;

    // 32-bit instances, latency 1 and 5, sharing stimulus
    logic        r32, w_valid, w_cin, w_flush;
    logic [3:0]  w_op;
    logic [31:0] w_in0, w_in1;
    logic        l1_valid, l1_carry, l1_ill, l5_valid, l5_carry, l5_ill;
    logic [31:0] l1_out, l5_out;

    int n_checks = 0;
    int n_fail   = 0;
    int issued   = 0;
    int seen     = 0;
    logic [17:0] exp_q [$];

    alu_pipe #(.DATA_W(16), .LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_op(in_op),
        .in0(in0), .in1(in1), .carryin(carryin), .flush(flush),
        .out_valid(out_valid), .out(out), .carryout(carryout), .out_illegal(out_illegal)
    );

    alu_pipe #(.DATA_W(32), .LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset(r32), .in_valid(w_valid), .in_op(w_op),
        .in0(w_in0), .in1(w_in1), .carryin(w_cin), .flush(w_flush),
        .out_valid(l1_valid), .out(l1_out), .carryout(l1_carry), .out_illegal(l1_ill)
    );

    alu_pipe #(.DATA_W(32), .LATENCY(5)) u_dut_l5 (
        .clock(clock), .reset(r32), .in_valid(w_valid), .in_op(w_op),
        .in0(w_in0), .in1(w_in1), .carryin(w_cin), .flush(w_flush),
        .out_valid(l5_valid), .out(l5_out), .carryout(l5_carry), .out_illegal(l5_ill)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
        in_valid = 1'b1;
        in_op    = op;
        in0      = a;
        in1      = b;
        carryin  = cin;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op    = 4'h0;
        in0      = '0;
        in1      = '0;
        carryin  = 1'b0;
    endtask

    // Single isolated op: not visible after one edge, visible with the expected fields after two.
    task automatic run_vec(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic cin, input logic [15:0] e_out,
                           input logic e_c, input logic e_ill);
        issue(op, a, b, cin);
        tick();
        check({tag, "_early"}, out_valid, 1'b0);
        idle();
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_out"}, out, e_out);
        check({tag, "_carry"}, carryout, e_c);
        check({tag, "_ill"}, out_illegal, e_ill);
    endtask

    function automatic logic [17:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
        logic [31:0] w;
        logic [15:0] d;
        logic        c;
        logic        il;
        w  = '0;
        d  = '0;
        c  = 1'b0;
        il = 1'b0;
        case (op)
            4'h0: d = a & b;
            4'h1: d = a | b;
            4'h2: d = a ^ b;
            4'h3: begin w = 32'(a) + 32'(b); d = w[15:0]; c = w[16]; end
            4'h4: begin w = 32'(a) + 32'(b) + 32'(cin); d = w[15:0]; c = w[16]; end
            4'h5: begin d = a - b; c = (a < b); end
            4'h6: d = (a == b) ? 16'd1 : 16'd0;
            4'h7: d = (a < b) ? 16'd1 : 16'd0;
            4'h8: d = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'h9: d = a << b[3:0];
            4'hA: d = a >> b[3:0];
`ifdef ALU_PIPE_MUL_EN
            4'hB: begin w = 32'(a) * 32'(b); d = w[15:0]; c = |w[31:16]; end
`endif
            default: il = 1'b1;
        endcase
        return {il, c, d};
    endfunction

    task automatic sample();
        logic [17:0] e;
        if (out_valid) begin
            seen++;
            if (exp_q.size() == 0) begin
                check("sb_spurious", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", {out_illegal, carryout, out}, e);
            end
        end else begin
            check("sb_idle_zero", {out_illegal, carryout, out}, 18'd0);
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        cin;

        reset   = 1'b1;
        r32     = 1'b1;
        flush   = 1'b0;
        w_valid = 1'b0;
        w_op    = 4'h0;
        w_in0   = '0;
        w_in1   = '0;
        w_cin   = 1'b0;
        w_flush = 1'b0;
        idle();
        #3;
        check("rst_state", {out_valid, out_illegal, carryout, out}, 19'd0);
        check("rst_state_l1", {l1_valid, l1_ill, l1_carry, l1_out}, 35'd0);
        check("rst_state_l5", {l5_valid, l5_ill, l5_carry, l5_out}, 35'd0);
        tick();
        tick();
        reset = 1'b0;
        r32   = 1'b0;
        tick();

        // Directed arithmetic and compare vectors
        run_vec("add_wrap", 4'h3, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_vec("addc",     4'h4, 16'h0003, 16'h0004, 1'b1, 16'h0008, 1'b0, 1'b0);
        run_vec("add_nocin",4'h3, 16'h0003, 16'h0004, 1'b1, 16'h0007, 1'b0, 1'b0);
        run_vec("sub",      4'h5, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        run_vec("slts",     4'h8, 16'h8000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_vec("sltu",     4'h7, 16'h8000, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_vec("seq",      4'h6, 16'h0003, 16'h0003, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_vec("sll",      4'h9, 16'h0001, 16'h0013, 1'b0, 16'h0008, 1'b0, 1'b0);
        run_vec("srl",      4'hA, 16'h8000, 16'h000F, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_vec("xor",      4'h2, 16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 1'b0, 1'b0);
        run_vec("illegal",  4'hF, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b1);
`ifdef ALU_PIPE_MUL_EN
        run_vec("mul",      4'hB, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0);
`else
        run_vec("mul_off",  4'hB, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1);
`endif

        // Flush: first op has already retired when flush is seen; later two are killed
        issue(4'h3, 16'd1, 16'd2, 1'b0);
        tick();
        issue(4'h3, 16'd10, 16'd20, 1'b0);
        tick();
        check("flush_pre_valid", out_valid, 1'b1);
        check("flush_pre_out", out, 16'd3);
        issue(4'h3, 16'd100, 16'd200, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue(4'h3, 16'd5, 16'd6, 1'b0);
        check("flush_kill_op2", out_valid, 1'b0);
        tick();
        idle();
        check("flush_kill_op3", out_valid, 1'b0);
        tick();
        check("flush_after_valid", out_valid, 1'b1);
        check("flush_after_out", out, 16'd11);
        tick();

        // Scoreboarded random traffic, mixing back-to-back and sparse issue
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                op  = 4'($urandom_range(0, 15));
                a   = 16'($urandom);
                b   = 16'($urandom);
                cin = 1'($urandom_range(0, 1));
                issue(op, a, b, cin);
                exp_q.push_back(model(op, a, b, cin));
                issued++;
            end else begin
                idle();
            end
            tick();
            sample();
        end
        idle();
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            sample();
        end
        check("sb_count", 64'(seen), 64'(issued));

        // Latency 1 vs latency 5 at DATA_W=32
        w_valid = 1'b1;
        w_op    = 4'h3;
        w_in0   = 32'hFFFF_FFFF;
        w_in1   = 32'h0000_0002;
        tick();
        w_valid = 1'b0;
        check("l1_valid", l1_valid, 1'b1);
        check("l1_out", l1_out, 32'h1);
        check("l1_carry", l1_carry, 1'b1);
        check("l5_early1", l5_valid, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            if (k == 2) check("l1_single_pulse", l1_valid, 1'b0);
            if (k < 5) check("l5_early", l5_valid, 1'b0);
        end
        check("l5_valid", l5_valid, 1'b1);
        check("l5_out", l5_out, 32'h1);
        check("l5_carry", l5_carry, 1'b1);
        tick();

        // Asynchronous reset mid-pipeline
        w_valid = 1'b1;
        w_in0   = 32'd7;
        w_in1   = 32'd8;
        tick();
        w_valid = 1'b0;
        check("rst_pre_l1_valid", l1_valid, 1'b1);
        #2;
        r32 = 1'b1;
        #1;
        check("rst_async_l1", {l1_valid, l1_ill, l1_carry, l1_out}, 35'd0);
        check("rst_async_l5", {l5_valid, l5_ill, l5_carry, l5_out}, 35'd0);
        r32 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rst_lost_l5", l5_valid, 1'b0);
            check("rst_lost_l1", l1_valid, 1'b0);
        end
        w_valid = 1'b1;
        w_in0   = 32'd1;
        w_in1   = 32'd1;
        tick();
        w_valid = 1'b0;
        check("rst_reissue_l1_valid", l1_valid, 1'b1);
        check("rst_reissue_l1_out", l1_out, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
